// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the timing generator and the
// receive-side sync decoder, plus the decoder's lock state encoding.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = 800;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = 525;

  // Timing counters and measurements are 10 bits wide and saturate at all-ones.
  localparam int              CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'd0,
    LOCK_CHECK    = 2'd1,
    LOCK_LOCKED   = 2'd2
  } lock_state_t;

  // Increment that sticks at CNT_MAX so a missing sync reads as "too long".
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one active-low sync input and flags its falling edge. Both
// registers reset high (sync idle) so reset never produces a false edge.
module sync_edge_detect (
  input  logic i_clk_25mhz,
  input  logic i_rst,
  input  logic i_sync,
  output logic o_fall
);

  logic sync_q;
  logic prev_q;

  // Input register followed by the previous-value register for edge detection.
  always_ff @(posedge i_clk_25mhz) begin
    // NOTE: non-blocking assignments let prev_q capture the old sync_q on the
    // same edge; blocking here would collapse the two stages into one.
    if (i_rst) begin
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= i_sync;
      prev_q <= sync_q;
    end
  end

  assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA decoder: turns active-low HSYNC/VSYNC plus 4:4:4 RGB back
// into pixel coordinates and a valid strobe, measures line/frame timing and
// reports lock against the nominal timing.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int V_TOTAL  = VGA_V_TOTAL
) (
  input  logic        i_clk_25mhz,
  input  logic        i_rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic [3:0]  i_red,
  input  logic [3:0]  i_green,
  input  logic [3:0]  i_blue,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_valid,
  output logic [11:0] o_rgb,
  output logic        o_sof,
  output logic [9:0]  o_h_total,
  output logic [9:0]  o_v_total,
  output logic        o_locked
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);

  logic        hs_fall;
  logic        vs_fall;
  logic [11:0] rgb_q;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  h_meas;
  logic [9:0]  v_meas;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic        line_bad;
  logic        frame_ok;
  logic        bad_line_seen;
  logic        sync_lost;
  logic        active;
  logic        pix_valid;
  lock_state_t state;
  logic        good_cnt;

  sync_edge_detect u_hsync_edge (
    .i_clk_25mhz (i_clk_25mhz),
    .i_rst       (i_rst),
    .i_sync      (i_hsync),
    .o_fall      (hs_fall)
  );

  sync_edge_detect u_vsync_edge (
    .i_clk_25mhz (i_clk_25mhz),
    .i_rst       (i_rst),
    .i_sync      (i_vsync),
    .o_fall      (vs_fall)
  );

  // RGB input register, aligned with the sync input registers.
  always_ff @(posedge i_clk_25mhz) begin
    if (i_rst) rgb_q <= '0;
    else       rgb_q <= {i_red, i_green, i_blue};
  end

  // Position of the pixel currently in the input register, plus window and
  // measurement decode; h_nxt/v_nxt become h_cnt/v_cnt on the next edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    h_meas    = sat_inc(h_cnt);
    v_meas    = sat_inc(v_cnt);
    h_nxt     = hs_fall ? '0 : h_meas;
    v_nxt     = v_cnt;
    if (vs_fall)      v_nxt = '0;
    else if (hs_fall) v_nxt = v_meas;
    line_bad  = hs_fall && (h_meas != H_TOT);
    frame_ok  = (v_meas == V_TOT) && !bad_line_seen && !line_bad;
    sync_lost = (h_cnt == CNT_MAX) || (v_cnt == CNT_MAX);
    active    = (h_nxt >= H_START) && (h_nxt <= H_END) &&
                (v_nxt >= V_START) && (v_nxt <= V_END);
    pix_valid = active && (state == LOCK_LOCKED);
  end

  // Line/frame counters and the measured periods, sampled on each sync fall.
  always_ff @(posedge i_clk_25mhz) begin
    if (i_rst) begin
      h_cnt         <= CNT_MAX;
      v_cnt         <= CNT_MAX;
      bad_line_seen <= 1'b0;
      o_h_total     <= '0;
      o_v_total     <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (hs_fall) o_h_total <= h_meas;
      if (vs_fall) o_v_total <= v_meas;
      if (vs_fall)       bad_line_seen <= 1'b0;
      else if (line_bad) bad_line_seen <= 1'b1;
    end
  end

  // Lock FSM: two consecutive good frames to lock, any timing error drops it.
  always_ff @(posedge i_clk_25mhz) begin
    if (i_rst) begin
      state    <= LOCK_UNLOCKED;
      good_cnt <= 1'b0;
      o_locked <= 1'b0;
    end else begin
      case (state)
        LOCK_UNLOCKED: begin
          good_cnt <= 1'b0;
          if (vs_fall) state <= LOCK_CHECK;
        end
        LOCK_CHECK: begin
          if (vs_fall) begin
            if (!frame_ok) begin
              good_cnt <= 1'b0;
            end else if (good_cnt) begin
              state    <= LOCK_LOCKED;
              o_locked <= 1'b1;
              good_cnt <= 1'b0;
            end else begin
              good_cnt <= 1'b1;
            end
          end
        end
        LOCK_LOCKED: begin
          if (line_bad || (vs_fall && !frame_ok) || sync_lost) begin
            state    <= LOCK_UNLOCKED;
            o_locked <= 1'b0;
          end
        end
        default: begin
          state    <= LOCK_UNLOCKED;
          o_locked <= 1'b0;
          good_cnt <= 1'b0;
        end
      endcase
    end
  end

  // Output register: coordinates and colour update only for valid pixels.
  always_ff @(posedge i_clk_25mhz) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_rgb   <= '0;
    end else begin
      o_valid <= pix_valid;
      o_sof   <= pix_valid && (h_nxt == H_START) && (v_nxt == V_START);
      if (pix_valid) begin
        o_x   <= h_nxt - H_START;
        o_y   <= v_nxt - V_START;
        o_rgb <= rgb_q;
      end
    end
  end

endmodule
